// File: rtl/demux2_reg.sv
// demux2_reg
//   Registered 1-to-2 demultiplexer. A single source stream is steered to one
//   of two sinks, each behind a one-entry holding register with valid/ready.
//   A burst lock keeps every beat of a multi-beat burst on the channel picked
//   by the first beat. Per-channel counters tally beats delivered to sinks.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   demux2_valid/ready/data/      source handshake, data, destination select
//   sel/last                      (sel sampled only in IDLE) and last flag
//   demux2_out{0,1}_valid/ready/  per-channel sink handshake, data, last flag
//   data/last
//   demux2_cnt{0,1}               16-bit wrapping count of delivered beats
module demux2_reg #(
  parameter int d_width   = 12,
  parameter int sel_width = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 demux2_valid,
  output logic                 demux2_ready,
  input  logic [d_width-1:0]   demux2_data,
  input  logic [sel_width-1:0] demux2_sel,
  input  logic                 demux2_last,
  output logic                 demux2_out0_valid,
  input  logic                 demux2_out0_ready,
  output logic [d_width-1:0]   demux2_out0_data,
  output logic                 demux2_out0_last,
  output logic                 demux2_out1_valid,
  input  logic                 demux2_out1_ready,
  output logic [d_width-1:0]   demux2_out1_data,
  output logic                 demux2_out1_last,
  output logic [15:0]          demux2_cnt0,
  output logic [15:0]          demux2_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic route;
  logic route_valid;
  logic route_ready;
  logic accept;
  logic load0, load1;
  logic drain0, drain1;

  always_comb begin
    route = 1'b0;
    case (state)
      IDLE:    route = demux2_sel[0];
      LOCK0:   route = 1'b0;
      LOCK1:   route = 1'b1;
      default: route = 1'b0;
    endcase
  end

  assign route_valid = route ? demux2_out1_valid : demux2_out0_valid;
  assign route_ready = route ? demux2_out1_ready : demux2_out0_ready;

  // Ready never depends on demux2_valid; during reset it reads 1 but the
  // accept term below is gated so nothing is captured.
  assign demux2_ready = !rst_n || !route_valid || route_ready;

  assign accept = rst_n && demux2_valid && demux2_ready;
  assign load0  = accept && !route;
  assign load1  = accept &&  route;
  assign drain0 = demux2_out0_valid && demux2_out0_ready;
  assign drain1 = demux2_out1_valid && demux2_out1_ready;

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!demux2_last) state_nxt = demux2_sel[0] ? LOCK1 : LOCK0;
        end
        LOCK0, LOCK1: begin
          if (demux2_last) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      demux2_out0_valid <= 1'b0;
      demux2_out0_data  <= '0;
      demux2_out0_last  <= 1'b0;
      demux2_out1_valid <= 1'b0;
      demux2_out1_data  <= '0;
      demux2_out1_last  <= 1'b0;
      demux2_cnt0       <= '0;
      demux2_cnt1       <= '0;
    end else begin
      state <= state_nxt;

      // A refill takes priority over a drain so valid stays high on
      // simultaneous drain and load.
      if (load0) begin
        demux2_out0_valid <= 1'b1;
        demux2_out0_data  <= demux2_data;
        demux2_out0_last  <= demux2_last;
      end else if (drain0) begin
        demux2_out0_valid <= 1'b0;
      end

      if (load1) begin
        demux2_out1_valid <= 1'b1;
        demux2_out1_data  <= demux2_data;
        demux2_out1_last  <= demux2_last;
      end else if (drain1) begin
        demux2_out1_valid <= 1'b0;
      end

      if (drain0) demux2_cnt0 <= demux2_cnt0 + 16'd1;
      if (drain1) demux2_cnt1 <= demux2_cnt1 + 16'd1;
    end
  end

endmodule

// File: doc/demux2_reg.md
# demux2_reg

Registered 1-to-2 demultiplexer for the datapath: one d_width-bit source stream is steered to one of two sinks, the inverse of the existing 2-to-1 result mux. Each output has a one-entry holding register with a valid/ready handshake. A burst lock keeps multi-beat transfers on one channel. Per-channel beat counters support debug and verification.

## Interface

Parameters:
- d_width, 12, data width of every data port
- sel_width, 1, select width; only bit 0 is decoded (0 selects channel 0, 1 selects channel 1)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk
- demux2_valid  input  1  source beat present
- demux2_ready  output  1  block accepts the beat this cycle
- demux2_data  input  d_width  source data
- demux2_sel  input  sel_width  destination select; only sampled in IDLE
- demux2_last  input  1  final beat of a burst
- demux2_out0_valid  output  1  channel 0 holding register full
- demux2_out0_ready  input  1  channel 0 sink accepts
- demux2_out0_data  output  d_width  channel 0 data
- demux2_out0_last  output  1  channel 0 last flag
- demux2_out1_valid, demux2_out1_ready, demux2_out1_data, demux2_out1_last: same as channel 0, for channel 1
- demux2_cnt0  output  16  beats delivered on channel 0
- demux2_cnt1  output  16  beats delivered on channel 1

## Operation

- A transfer occurs when a valid and its matching ready are both 1 in the same cycle. This applies to the source and to each output.
- Route channel r:
  - In IDLE: r = demux2_sel[0].
  - In LOCK0: r = 0.
  - In LOCK1: r = 1.
- demux2_ready = !outr_valid || outr_ready. This path is combinational from sel, the state and the output ready; there is no path from demux2_valid.
- On an accepted beat:
  - Channel r register loads data and last.
  - Channel r valid is set.
  - The other channel is untouched.
- Output drain: when outN_valid && outN_ready and there is no refill of channel N in the same cycle, outN_valid clears. Data and last keep their previous values.
- Drain and refill of the same channel in the same cycle: valid stays 1 and data/last take the new beat (full throughput).
- State machine; transitions happen only on accepted beats:
  - IDLE → LOCK{sel[0]} when the beat has last=0.
  - IDLE → IDLE when the beat has last=1 (single-beat burst).
  - LOCKn → IDLE when the beat has last=1.
  - LOCKn → LOCKn when the beat has last=0.
  - demux2_sel is ignored in LOCKn.
  - Without an accepted beat, the state holds.
- Counters: demux2_cntN increments by 1 on each output-side transfer of channel N. It wraps from 16'hFFFF to 16'h0000 with no flag.
- A source that drops valid mid-burst does not release the lock; the block stays in LOCKn until a last beat is accepted.

## Timing

- Latency: a beat accepted at edge k is visible on outN_* immediately after edge k (one register stage).
- Sustained throughput: 1 beat/cycle per channel while the sink holds ready=1.
- When channel r is full and its sink is stalled, demux2_ready=0, even if the other channel is empty. There is no bypass to the other channel; ordering is strictly preserved.
- Reset (rst_n=0 at a rising edge), with any state:
  - State → IDLE.
  - out0/out1 valid → 0.
  - out0/out1 data → 0.
  - out0/out1 last → 0.
  - cnt0/cnt1 → 0.
  - While rst_n=0, demux2_ready reads 1 combinationally, but no beat is captured.
  - Reset mid-burst discards the lock and any held beats.
- Outputs are stable between edges except demux2_ready, which is the only combinational output.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with random inputs → all valid=0, data=0, last=0, cnt0=cnt1=0, state IDLE.
- Single beats: sel=0 data=12'h0A5 last=1, then sel=1 data=12'h5A0 last=1, both sinks ready=1 → out0 shows 12'h0A5 one cycle after accept, then out1 shows 12'h5A0; cnt0=1, cnt1=1.
- Burst lock: beats 12'h001, 12'h002, 12'h003 with last on the third; sel=0 on the first beat and sel=1 on the later beats → all three appear on out0; out0_last=1 only with 12'h003; state returns to IDLE.
- Backpressure:
  - Stimulus: out0_ready=0, then 2 beats sent to channel 0.
  - Expected: first beat held; demux2_ready=0 on the second beat.
  - Then raise out0_ready=1 → drain and refill in the same cycle, valid stays 1, second beat follows. Channel 1 is unaffected throughout.
- Counter wrap: preload by streaming 65536 channel-1 beats with ready=1 → cnt1 reads 16'h0000; next beat → 16'h0001.
- Reset mid-burst: in LOCK1 with out1 full, assert rst_n=0 for 1 cycle → out1_valid=0; next beat with sel=0 routes to channel 0.
